alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Multi-cycle issue controller in front of the combinational 32-bit ALU (opcode[4:0], A, B in; 64-bit C out).
- Accepts one operation at a time over a valid/ready request port and drives registered operands and opcode into the ALU.
- Holds the operands for an opcode-dependent settle time so long mul/div carry chains meet timing, then captures C into LO/HI result registers.
- Returns the result over a valid/ready response port; sits between the control unit and the ALU/HI-LO register pair.

Parameters:
- WORD_SIZE, 32, operand width; the result is 2*WORD_SIZE.
- SIMPLE_LAT, 1, settle cycles for opcodes 1-2 and 5-15 (minimum 1).
- MUL_LAT, 4, settle cycles for mul (opcode 3), minimum 1.
- DIV_LAT, 8, settle cycles for div (opcode 4), minimum 1.

Ports:
- clk  in  1  system clock
- clr  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_opcode  in  5  ALU opcode
- req_a  in  WORD_SIZE  operand A
- req_b  in  WORD_SIZE  operand B
- alu_a  out  WORD_SIZE  registered operand A to the ALU
- alu_b  out  WORD_SIZE  registered operand B to the ALU
- alu_opcode  out  5  registered opcode to the ALU
- alu_c  in  2*WORD_SIZE  ALU result
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes the result
- resp_lo  out  WORD_SIZE  captured alu_c[WORD_SIZE-1:0]
- resp_hi  out  WORD_SIZE  captured alu_c[2*WORD_SIZE-1:WORD_SIZE]
- resp_illegal  out  1  opcode was outside 1..15
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk. clr is synchronous and active-high.
- Reset values: state IDLE; req_ready=1; resp_valid=0; busy=0; alu_a, alu_b, alu_opcode, resp_lo, resp_hi and resp_illegal all 0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, register req_a/req_b/req_opcode into alu_a/alu_b/alu_opcode.
  - Load the down-counter with lat-1: lat = MUL_LAT for opcode 3, DIV_LAT for opcode 4, otherwise SIMPLE_LAT.
  - Go to EXEC.
- EXEC:
  - req_ready=0; alu_* held stable.
  - Counter decrements each cycle.
  - In the cycle the counter is 0, capture alu_c into resp_hi/resp_lo, set resp_valid=1 and go to RESP.
  - Latency from the accept edge to resp_valid high is lat+1 cycles (SIMPLE_LAT=1: resp_valid rises 2 cycles after accept).
- RESP:
  - resp_valid=1; resp_lo/resp_hi/resp_illegal held stable.
  - On resp_ready, clear resp_valid and return to IDLE; req_ready is high the next cycle.
  - No request bypass, so sustained throughput is one op per lat+2 cycles.
- Illegal opcode (0 or 16-31):
  - Accepted, but skips EXEC.
  - Next cycle: RESP with resp_lo=resp_hi=0 and resp_illegal=1.
  - alu_opcode is still driven with the value, so the ALU default yields 0.
- resp_valid must not drop without resp_ready, and the data must not change while resp_valid=1.
- clr has priority over everything, including mid-EXEC and mid-RESP.
  - An in-flight op is discarded with no response.
  - All outputs return to their reset values the next cycle.
- req_valid in EXEC/RESP is ignored (req_ready=0); the requester holds it.
- The counter width must be sized to max(MUL_LAT, DIV_LAT, SIMPLE_LAT).

Optional Feature:
- Macro: ALU_SEQ_FLAGS_EN.
- When defined:
  - Adds outputs resp_zero (1) and resp_neg (1), registered at capture time.
  - resp_zero = (alu_c == 0).
  - resp_neg = alu_c[WORD_SIZE-1] for all opcodes except mul, which uses alu_c[2*WORD_SIZE-1].
  - Both are 0 for illegal opcodes; reset value 0.
- When undefined: the ports and their logic are absent, and all other behaviour is unchanged.

Decomposition:
- Shared package/include holds the opcode constants (ADD=1, SUB=2, MUL=3, DIV=4, SHR=5, SHL=6, SHRA=7, ROR=8, ROL=9, AND=10, OR=11, NEG=12, XOR=13, NOR=14, NOT=15), the state encoding, and an opcode-legal helper function; the ALU and this block both consume it.
- One natural sub-module: alu_lat_counter, the loadable down-counter with a zero flag.

Test Plan:
- Reset/idle: assert clr for 2 cycles, release -> req_ready=1, resp_valid=0, busy=0, all data outputs 0.
- Add: opcode 1, A=5, B=7, resp_ready=1 -> resp_valid rises exactly 2 cycles after accept with resp_lo=12, resp_hi=0; req_ready=1 one cycle after the response handshake.
- Mul latency: opcode 3, A=0x0001_0000, B=0x0001_0000 -> resp_valid 5 cycles after accept with resp_hi=1, resp_lo=0; alu_a/alu_b stable throughout EXEC.
- Backpressure: div A=100, B=7 with resp_ready=0 for 10 cycles -> resp_valid stays 1 and resp_lo/resp_hi constant; a second req_valid in that window is not accepted (req_ready=0).
- Illegal/reset mid-op: opcode 0 -> resp_illegal=1, result 0, one cycle after accept. Separately, clr asserted mid-EXEC of a div -> no resp_valid, and state returns to IDLE the next cycle.
- Flags (ALU_SEQ_FLAGS_EN defined): sub A=3, B=3 -> resp_zero=1, resp_neg=0; sub A=3, B=5 -> resp_neg=1, resp_lo=0xFFFF_FFFE.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU issue path: opcode map, sequencer state
// encoding and the opcode legality helper.
package alu_op_sequencer_pkg;

  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_MUL  = 5'd3;
  localparam logic [4:0] OP_DIV  = 5'd4;
  localparam logic [4:0] OP_SHR  = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_SHRA = 5'd7;
  localparam logic [4:0] OP_ROR  = 5'd8;
  localparam logic [4:0] OP_ROL  = 5'd9;
  localparam logic [4:0] OP_AND  = 5'd10;
  localparam logic [4:0] OP_OR   = 5'd11;
  localparam logic [4:0] OP_NEG  = 5'd12;
  localparam logic [4:0] OP_XOR  = 5'd13;
  localparam logic [4:0] OP_NOR  = 5'd14;
  localparam logic [4:0] OP_NOT  = 5'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_e;

  // Legal opcodes are 1..15: nonzero with the top bit clear.
  function automatic logic opcode_legal(input logic [4:0] op);
    return (op != 5'd0) && (op[4] == 1'b0);
  endfunction

endpackage

// File: rtl/alu_lat_counter.sv
// Loadable down-counter that times the ALU settle window; zero marks the
// last settle cycle.
module alu_lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle issue controller for the combinational ALU: holds operands for
// an opcode-dependent settle time, then returns the captured 64-bit result.
// Optional flag outputs resp_zero/resp_neg are built when ALU_SEQ_FLAGS_EN is defined.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high; valid never drops and its payload never changes until that edge.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int WORD_SIZE  = 32,
  parameter int SIMPLE_LAT = 1,
  parameter int MUL_LAT    = 4,
  parameter int DIV_LAT    = 8
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [4:0]             req_opcode,
  input  logic [WORD_SIZE-1:0]   req_a,
  input  logic [WORD_SIZE-1:0]   req_b,
  output logic [WORD_SIZE-1:0]   alu_a,
  output logic [WORD_SIZE-1:0]   alu_b,
  output logic [4:0]             alu_opcode,
  input  logic [2*WORD_SIZE-1:0] alu_c,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [WORD_SIZE-1:0]   resp_lo,
  output logic [WORD_SIZE-1:0]   resp_hi,
  output logic                   resp_illegal,
  output logic                   busy,
  output logic [1:0]             dbg_state
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic                   resp_zero,
  output logic                   resp_neg
`endif
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT)
                         ? ((MUL_LAT > SIMPLE_LAT) ? MUL_LAT : SIMPLE_LAT)
                         : ((DIV_LAT > SIMPLE_LAT) ? DIV_LAT : SIMPLE_LAT);
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  seq_state_e             state_q, state_d;
  logic [WORD_SIZE-1:0]   alu_a_q, alu_a_d;
  logic [WORD_SIZE-1:0]   alu_b_q, alu_b_d;
  logic [4:0]             alu_opcode_q, alu_opcode_d;
  logic [WORD_SIZE-1:0]   resp_lo_q, resp_lo_d;
  logic [WORD_SIZE-1:0]   resp_hi_q, resp_hi_d;
  logic                   resp_illegal_q, resp_illegal_d;
`ifdef ALU_SEQ_FLAGS_EN
  logic                   resp_zero_q, resp_zero_d;
  logic                   resp_neg_q, resp_neg_d;
`endif

  logic                   cnt_load;
  logic                   cnt_dec;
  logic                   cnt_zero;
  logic [CNT_W-1:0]       cnt_load_val;
  int                     lat_sel;

  // Settle time is chosen from the incoming opcode so it is ready at accept.
  always_comb begin
    if (req_opcode == OP_MUL) begin
      lat_sel = MUL_LAT;
    end else if (req_opcode == OP_DIV) begin
      lat_sel = DIV_LAT;
    end else begin
      lat_sel = SIMPLE_LAT;
    end
    cnt_load_val = CNT_W'(lat_sel - 1);
  end

  alu_lat_counter #(
    .CNT_W (CNT_W)
  ) u_lat_counter (
    .clk      (clk),
    .clr      (clr),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d        = state_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_opcode_d   = alu_opcode_q;
    resp_lo_d      = resp_lo_q;
    resp_hi_d      = resp_hi_q;
    resp_illegal_d = resp_illegal_q;
`ifdef ALU_SEQ_FLAGS_EN
    resp_zero_d    = resp_zero_q;
    resp_neg_d     = resp_neg_q;
`endif
    cnt_load       = 1'b0;
    cnt_dec        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          alu_a_d      = req_a;
          alu_b_d      = req_b;
          alu_opcode_d = req_opcode;
          if (opcode_legal(req_opcode)) begin
            cnt_load = 1'b1;
            state_d  = ST_EXEC;
          end else begin
            // Illegal ops answer immediately with a zero result.
            resp_lo_d      = '0;
            resp_hi_d      = '0;
            resp_illegal_d = 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
            resp_zero_d    = 1'b0;
            resp_neg_d     = 1'b0;
`endif
            state_d        = ST_RESP;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_zero) begin
          resp_lo_d      = alu_c[WORD_SIZE-1:0];
          resp_hi_d      = alu_c[2*WORD_SIZE-1:WORD_SIZE];
          resp_illegal_d = 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
          resp_zero_d    = (alu_c == '0);
          resp_neg_d     = (alu_opcode_q == OP_MUL) ? alu_c[2*WORD_SIZE-1]
                                                    : alu_c[WORD_SIZE-1];
`endif
          state_d        = ST_RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q        <= ST_IDLE;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_opcode_q   <= '0;
      resp_lo_q      <= '0;
      resp_hi_q      <= '0;
      resp_illegal_q <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      resp_zero_q    <= 1'b0;
      resp_neg_q     <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_opcode_q   <= alu_opcode_d;
      resp_lo_q      <= resp_lo_d;
      resp_hi_q      <= resp_hi_d;
      resp_illegal_q <= resp_illegal_d;
`ifdef ALU_SEQ_FLAGS_EN
      resp_zero_q    <= resp_zero_d;
      resp_neg_q     <= resp_neg_d;
`endif
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign resp_valid   = (state_q == ST_RESP);
  assign busy         = (state_q != ST_IDLE);
  assign dbg_state    = state_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_opcode   = alu_opcode_q;
  assign resp_lo      = resp_lo_q;
  assign resp_hi      = resp_hi_q;
  assign resp_illegal = resp_illegal_q;
`ifdef ALU_SEQ_FLAGS_EN
  assign resp_zero    = resp_zero_q;
  assign resp_neg     = resp_neg_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small behavioural ALU on alu_c.
// Flag checks are compiled in when ALU_SEQ_FLAGS_EN is defined.
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  localparam int W = 32;

  logic           clk;
  logic           clr;
  logic           req_valid;
  logic           req_ready;
  logic [4:0]     req_opcode;
  logic [W-1:0]   req_a;
  logic [W-1:0]   req_b;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [4:0]     alu_opcode;
  logic [2*W-1:0] alu_c;
  logic           resp_valid;
  logic           resp_ready;
  logic [W-1:0]   resp_lo;
  logic [W-1:0]   resp_hi;
  logic           resp_illegal;
  logic           busy;
  logic [1:0]     dbg_state;
`ifdef ALU_SEQ_FLAGS_EN
  logic           resp_zero;
  logic           resp_neg;
`endif

  int checks = 0;
  int errors = 0;

  alu_op_sequencer dut (
    .clk          (clk),
    .clr          (clr),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_opcode   (req_opcode),
    .req_a        (req_a),
    .req_b        (req_b),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_opcode   (alu_opcode),
    .alu_c        (alu_c),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_lo      (resp_lo),
    .resp_hi      (resp_hi),
    .resp_illegal (resp_illegal),
    .busy         (busy),
    .dbg_state    (dbg_state)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .resp_zero    (resp_zero),
    .resp_neg     (resp_neg)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: hi holds the remainder for div, the upper product for mul.
  logic [2*W-1:0] prod;
  always_comb begin
    prod  = {{W{1'b0}}, alu_a} * {{W{1'b0}}, alu_b};
    alu_c = '0;
    case (alu_opcode)
      5'd1:  alu_c = {{W{1'b0}}, alu_a + alu_b};
      5'd2:  alu_c = {{W{1'b0}}, alu_a - alu_b};
      5'd3:  alu_c = prod;
      5'd4:  alu_c = (alu_b != '0) ? {alu_a % alu_b, alu_a / alu_b} : '0;
      5'd10: alu_c = {{W{1'b0}}, alu_a & alu_b};
      default: alu_c = '0;
    endcase
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid  = 1'b1;
    req_opcode = op;
    req_a      = a;
    req_b      = b;
  endtask

  initial begin
    clr        = 1'b1;
    req_valid  = 1'b0;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;

    // Reset / idle
    tick(2);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("rst_alu_a", 64'(alu_a), 64'd0);
    check("rst_alu_b", 64'(alu_b), 64'd0);
    check("rst_alu_op", 64'(alu_opcode), 64'd0);
    check("rst_lo", 64'(resp_lo), 64'd0);
    check("rst_hi", 64'(resp_hi), 64'd0);
    check("rst_illegal", 64'(resp_illegal), 64'd0);
    clr = 1'b0;
    tick(1);

    // Add 5+7: response two edges after presenting the request
    drive_req(5'd1, 32'd5, 32'd7);
    check("add_ready_pre", 64'(req_ready), 64'd1);
    tick(1);
    req_valid = 1'b0;
    check("add_busy", 64'(busy), 64'd1);
    check("add_ready_exec", 64'(req_ready), 64'd0);
    check("add_valid_early", 64'(resp_valid), 64'd0);
    check("add_alu_a", 64'(alu_a), 64'd5);
    tick(1);
    check("add_valid", 64'(resp_valid), 64'd1);
    check("add_lo", 64'(resp_lo), 64'd12);
    check("add_hi", 64'(resp_hi), 64'd0);
    check("add_illegal", 64'(resp_illegal), 64'd0);
    resp_ready = 1'b1;
    tick(1);
    resp_ready = 1'b0;
    check("add_valid_drop", 64'(resp_valid), 64'd0);
    check("add_ready_post", 64'(req_ready), 64'd1);

    // Mul latency: 5 edges from presentation, operands stable throughout
    drive_req(5'd3, 32'h0001_0000, 32'h0001_0000);
    tick(1);
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("mul_valid_early", 64'(resp_valid), 64'd0);
      check("mul_alu_a_stable", 64'(alu_a), 64'h0001_0000);
      check("mul_alu_b_stable", 64'(alu_b), 64'h0001_0000);
      tick(1);
    end
    check("mul_valid", 64'(resp_valid), 64'd1);
    check("mul_hi", 64'(resp_hi), 64'd1);
    check("mul_lo", 64'(resp_lo), 64'd0);
    resp_ready = 1'b1;
    tick(1);
    resp_ready = 1'b0;

    // Div with backpressure and a competing request
    drive_req(5'd4, 32'd100, 32'd7);
    tick(1);
    req_valid = 1'b0;
    tick(7);
    check("div_valid_early", 64'(resp_valid), 64'd0);
    tick(1);
    check("div_valid", 64'(resp_valid), 64'd1);
    check("div_lo", 64'(resp_lo), 64'd14);
    check("div_hi", 64'(resp_hi), 64'd2);
    drive_req(5'd1, 32'd1, 32'd2);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("bp_valid", 64'(resp_valid), 64'd1);
      check("bp_lo", 64'(resp_lo), 64'd14);
      check("bp_hi", 64'(resp_hi), 64'd2);
      check("bp_req_ready", 64'(req_ready), 64'd0);
      check("bp_alu_op", 64'(alu_opcode), 64'd4);
    end
    resp_ready = 1'b1;
    tick(1);
    check("bp_release_valid", 64'(resp_valid), 64'd0);
    check("bp_release_ready", 64'(req_ready), 64'd1);
    tick(1);
    req_valid = 1'b0;
    check("held_req_op", 64'(alu_opcode), 64'd1);
    check("held_req_busy", 64'(busy), 64'd1);
    tick(1);
    check("held_req_valid", 64'(resp_valid), 64'd1);
    check("held_req_lo", 64'(resp_lo), 64'd3);
    tick(1);
    resp_ready = 1'b0;
    check("held_req_done", 64'(resp_valid), 64'd0);

    // Illegal opcode 0: response one edge after accept
    drive_req(5'd0, 32'd9, 32'd9);
    tick(1);
    req_valid = 1'b0;
    check("ill0_valid", 64'(resp_valid), 64'd1);
    check("ill0_flag", 64'(resp_illegal), 64'd1);
    check("ill0_lo", 64'(resp_lo), 64'd0);
    check("ill0_hi", 64'(resp_hi), 64'd0);
    check("ill0_alu_a", 64'(alu_a), 64'd9);
    resp_ready = 1'b1;
    tick(1);
    resp_ready = 1'b0;

    // Illegal opcode 20, still forwarded to the ALU
    drive_req(5'd20, 32'd1, 32'd1);
    tick(1);
    req_valid = 1'b0;
    check("ill20_valid", 64'(resp_valid), 64'd1);
    check("ill20_flag", 64'(resp_illegal), 64'd1);
    check("ill20_alu_op", 64'(alu_opcode), 64'd20);
    resp_ready = 1'b1;
    tick(1);
    resp_ready = 1'b0;

    // AND after an illegal op clears the illegal flag
    drive_req(5'd10, 32'hF0F0_1234, 32'h0FF0_FF00);
    tick(2);
    req_valid = 1'b0;
    check("and_valid", 64'(resp_valid), 64'd1);
    check("and_lo", 64'(resp_lo), 64'h00F0_1200);
    check("and_illegal", 64'(resp_illegal), 64'd0);
    resp_ready = 1'b1;
    tick(1);
    resp_ready = 1'b0;

    // clr in the middle of a div: no response, everything back to reset
    drive_req(5'd4, 32'd50, 32'd5);
    tick(1);
    req_valid = 1'b0;
    tick(3);
    check("clr_mid_state", 64'(dbg_state), 64'(ST_EXEC));
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("clr_state", 64'(dbg_state), 64'(ST_IDLE));
    check("clr_valid", 64'(resp_valid), 64'd0);
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_ready", 64'(req_ready), 64'd1);
    check("clr_alu_a", 64'(alu_a), 64'd0);
    check("clr_lo", 64'(resp_lo), 64'd0);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("clr_no_resp", 64'(resp_valid), 64'd0);
    end

`ifdef ALU_SEQ_FLAGS_EN
    // Flags: 3-3 is zero, 3-5 is negative
    drive_req(5'd2, 32'd3, 32'd3);
    tick(2);
    req_valid = 1'b0;
    check("sub0_valid", 64'(resp_valid), 64'd1);
    check("sub0_zero", 64'(resp_zero), 64'd1);
    check("sub0_neg", 64'(resp_neg), 64'd0);
    resp_ready = 1'b1;
    tick(1);
    resp_ready = 1'b0;
    drive_req(5'd2, 32'd3, 32'd5);
    tick(2);
    req_valid = 1'b0;
    check("subn_valid", 64'(resp_valid), 64'd1);
    check("subn_lo", 64'(resp_lo), 64'hFFFF_FFFE);
    check("subn_neg", 64'(resp_neg), 64'd1);
    check("subn_zero", 64'(resp_zero), 64'd0);
    resp_ready = 1'b1;
    tick(1);
    resp_ready = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
